// File: rtl/sipo_if.sv
// Serial-in / parallel-out link: serial bit stream in, handshaked parallel words and error pulses out.
interface sipo_if #(
    parameter int unsigned WIDTH = 8
);
    logic             serial_in;
    logic             in_valid;
    logic             in_start;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             overrun;
    logic             frame_err;
    logic             parity_err;

    modport master (
        output serial_in, in_valid, in_start, out_ready,
        input  out_data, out_valid, overrun, frame_err, parity_err
    );

    modport slave (
        input  serial_in, in_valid, in_start, out_ready,
        output out_data, out_valid, overrun, frame_err, parity_err
    );
endinterface

// File: rtl/sipo_deserializer.sv
// Serial-to-parallel deserializer with start-strobe framing and a one-entry valid/ready output.
// Define SIPO_PARITY_EN to expect an even-parity bit after each WIDTH-bit data frame.
module sipo_deserializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          LSB_FIRST = 1'b1
) (
    input logic   clk,
    input logic   rst,
    sipo_if.slave bus
);
    localparam int unsigned CntW = $clog2(WIDTH);

`ifdef SIPO_PARITY_EN
    typedef enum logic [1:0] {StIdle, StShift, StParity} state_e;
`else
    typedef enum logic [0:0] {StIdle, StShift} state_e;
`endif

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;
    logic             ferr_q, ferr_d;
    logic             perr_q, perr_d;
    logic             complete;
    logic [WIDTH-1:0] word;

    function automatic logic [CntW-1:0] bit_pos(input logic [CntW-1:0] idx);
        return LSB_FIRST ? idx : CntW'(WIDTH - 1) - idx;
    endfunction

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sreg_d   = sreg_q;
        complete = 1'b0;
        ferr_d   = 1'b0;
        perr_d   = 1'b0;
        word     = sreg_q;

        if (bus.in_valid) begin
            if (bus.in_start) begin
                // A start strobe always opens a new frame, aborting any partial one.
                ferr_d                 = (state_q != StIdle);
                sreg_d                 = '0;
                sreg_d[bit_pos('0)]    = bus.serial_in;
                cnt_d                  = CntW'(1);
                state_d                = StShift;
            end else begin
                unique case (state_q)
                    StIdle: ;
                    StShift: begin
                        word[bit_pos(cnt_q)] = bus.serial_in;
                        sreg_d               = word;
                        cnt_d                = cnt_q + CntW'(1);
                        if (cnt_q == CntW'(WIDTH - 1)) begin
                            cnt_d = '0;
`ifdef SIPO_PARITY_EN
                            state_d = StParity;
`else
                            complete = 1'b1;
                            sreg_d   = '0;
                            state_d  = StIdle;
`endif
                        end
                    end
`ifdef SIPO_PARITY_EN
                    StParity: begin
                        complete = 1'b1;
                        perr_d   = (^sreg_q) ^ bus.serial_in;
                        sreg_d   = '0;
                        state_d  = StIdle;
                    end
`endif
                    default: state_d = StIdle;
                endcase
            end
        end
    end

    // Output register: a completing word loads if the slot is free or being drained this cycle.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = 1'b0;
        if (complete) begin
            if (!valid_q || bus.out_ready) begin
                data_d  = word;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && bus.out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            sreg_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sreg_q  <= sreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            ferr_q  <= ferr_d;
            perr_q  <= perr_d;
        end
    end

    assign bus.out_data  = data_q;
    assign bus.out_valid = valid_q;
    assign bus.overrun   = ovr_q;
    assign bus.frame_err = ferr_q;
`ifdef SIPO_PARITY_EN
    assign bus.parity_err = perr_q;
`else
    assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_deserializer.sv
// Self-checking bench for sipo_deserializer: directed and random frames against a frame-level model.
module tb_sipo_deserializer;
    localparam int W   = 8;
    localparam int IW  = $clog2(W);
    localparam bit LSB = 1'b1;
`ifdef SIPO_PARITY_EN
    localparam int FRAME = W + 1;
`else
    localparam int FRAME = W;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sipo_if #(.WIDTH(W)) bus ();

    sipo_deserializer #(.WIDTH(W), .LSB_FIRST(LSB)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state: bits of the open frame and the output slot.
    bit           bits[$];
    bit           in_frame;
    logic         m_valid;
    logic [W-1:0] m_data;
    logic         e_ovr, e_ferr, e_perr;

    function automatic int pos(int k);
        return LSB ? k : W - 1 - k;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        bits.delete();
        in_frame = 1'b0;
        m_valid  = 1'b0;
        m_data   = '0;
        e_ovr    = 1'b0;
        e_ferr   = 1'b0;
        e_perr   = 1'b0;
    endtask

    task automatic model(logic v, logic s, logic d, logic r);
        bit           done;
        bit           par;
        logic [W-1:0] w;
        done   = 1'b0;
        e_ovr  = 1'b0;
        e_ferr = 1'b0;
        e_perr = 1'b0;
        if (v) begin
            if (s) begin
                if (in_frame) e_ferr = 1'b1;
                bits.delete();
                bits.push_back(d);
                in_frame = 1'b1;
            end else if (in_frame) begin
                bits.push_back(d);
            end
            if (in_frame && bits.size() == FRAME) begin
                done     = 1'b1;
                in_frame = 1'b0;
            end
        end
        if (done) begin
            w   = '0;
            par = 1'b0;
            for (int k = 0; k < W; k++) w[IW'(pos(k))] = bits[k];
            for (int k = 0; k < FRAME; k++) par ^= bits[k];
`ifdef SIPO_PARITY_EN
            e_perr = par;
`endif
            if (!m_valid || r) begin
                m_data  = w;
                m_valid = 1'b1;
            end else begin
                e_ovr = 1'b1;
            end
        end else if (m_valid && r) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic check_outputs();
        chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
        chk("out_data", 32'(bus.out_data), 32'(m_data));
        chk("overrun", 32'(bus.overrun), 32'(e_ovr));
        chk("frame_err", 32'(bus.frame_err), 32'(e_ferr));
        chk("parity_err", 32'(bus.parity_err), 32'(e_perr));
    endtask

    task automatic step(logic v, logic s, logic d, logic r);
        bus.serial_in = d;
        bus.in_valid  = v;
        bus.in_start  = s;
        bus.out_ready = r;
        model(v, s, d, r);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    function automatic logic rr(int mode);
        return (mode == 2) ? 1'($urandom_range(0, 1)) : 1'(mode);
    endfunction

    // Sends the first nbits of a frame for 'word'; bit index W is the (optionally corrupted) parity.
    task automatic send_bits(logic [W-1:0] word, int nbits, bit gaps, int rmode, bit bad_par);
        logic b;
        for (int k = 0; k < nbits; k++) begin
            if (k < W) b = word[IW'(pos(k))];
            else b = (^word) ^ bad_par;
            if (gaps && k > 0)
                step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rr(rmode));
            step(1'b1, k == 0, b, rr(rmode));
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.serial_in = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_start  = 1'b0;
        bus.out_ready = 1'b0;
        model_reset();
        #12;
        check_outputs();
        @(negedge clk);
        rst = 1'b0;

        // 0xA5, continuous bits, ready high: word visible one clock after the last bit.
        send_bits(8'hA5, FRAME, 1'b0, 1, 1'b0);
        chk("a5_valid", 32'(bus.out_valid), 32'd1);
        chk("a5_data", 32'(bus.out_data), 32'hA5);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // Overrun: 0x3C held while 0xC3 completes with ready low.
        send_bits(8'h3C, FRAME, 1'b0, 0, 1'b0);
        send_bits(8'hC3, FRAME, 1'b0, 0, 1'b0);
        chk("ovr_pulse", 32'(bus.overrun), 32'd1);
        chk("ovr_hold", 32'(bus.out_data), 32'h3C);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("ovr_drained", 32'(bus.out_valid), 32'd0);

        // Early start after 4 bits aborts the frame; 0x5A follows.
        send_bits(8'h12, 4, 1'b0, 1, 1'b0);
        send_bits(8'h5A, FRAME, 1'b0, 1, 1'b0);
        chk("abort_data", 32'(bus.out_data), 32'h5A);

        // Gapped 0xF0 then 0x0F back-to-back with no dead cycle.
        send_bits(8'hF0, FRAME, 1'b1, 1, 1'b0);
        chk("gap_data", 32'(bus.out_data), 32'hF0);
        send_bits(8'h0F, FRAME, 1'b0, 1, 1'b0);
        chk("b2b_data", 32'(bus.out_data), 32'h0F);
        step(1'b0, 1'b0, 1'b0, 1'b1);

`ifdef SIPO_PARITY_EN
        send_bits(8'h07, FRAME, 1'b0, 1, 1'b0);
        chk("par_ok", 32'(bus.parity_err), 32'd0);
        send_bits(8'h07, FRAME, 1'b0, 1, 1'b1);
        chk("par_bad", 32'(bus.parity_err), 32'd1);
        chk("par_bad_data", 32'(bus.out_data), 32'h07);
        step(1'b0, 1'b0, 1'b0, 1'b1);
`endif

        // Random frames: random words, gaps, ready patterns, aborts, stray bits.
        repeat (40) begin
            int n;
            n = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, FRAME - 1)) : FRAME;
            send_bits(W'($urandom), n, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
                      $urandom_range(0, 3) == 0);
            repeat ($urandom_range(0, 2))
                step(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)), rr(2));
        end

        // Asynchronous reset mid-frame with a word pending clears everything at once.
        send_bits(8'h99, FRAME, 1'b0, 0, 1'b0);
        send_bits(8'h66, 3, 1'b0, 0, 1'b0);
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_data", 32'(bus.out_data), 32'd0);
        chk("rst_ovr", 32'(bus.overrun), 32'd0);
        chk("rst_ferr", 32'(bus.frame_err), 32'd0);
        chk("rst_perr", 32'(bus.parity_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        send_bits(8'hC6, FRAME, 1'b0, 1, 1'b0);
        chk("post_rst_data", 32'(bus.out_data), 32'hC6);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end
endmodule
